spi_xfer_ctrl: RTL and testbench

//  APB3 slave controller that sequences one full-duplex SPI master transfer
//  per software START. It holds the CTRL/STATUS/TXDATA/RXDATA/CLKDIV registers
//  and runs the transfer state machine that drives SCLK/MOSI/CS_N and samples MISO.
//  It sits between the APB interconnect and the SPI pads; the status flags replace
//  the standalone PSEL-set status register.

---
 rtl/spi_xfer_ctrl_pkg.sv | 30 +++
 rtl/spi_xfer_ctrl_if.sv | 26 ++
 rtl/spi_xfer_ctrl_clk_div.sv | 36 +++
 rtl/spi_xfer_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared register map, control/status bit positions and transfer states for the
// APB-attached SPI master transfer controller.
package spi_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_RXDATA = 8'h0C;
  localparam logic [7:0] OFF_CLKDIV = 8'h10;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CPOL   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spi_state_t;

  // Byte offset compare, narrowed to the bus address width in use.
  function automatic logic addr_is(input logic [7:0] addr, input logic [7:0] off);
    return addr == off;
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// APB3 completer-side bus bundle for spi_xfer_ctrl; the interconnect drives the
// master modport, the controller uses the slave modport.
interface spi_xfer_ctrl_if #(
  parameter int ADDR_W = 5
);

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/spi_xfer_ctrl_clk_div.sv
// Loadable SCLK half-period counter: after a load it emits a one-cycle strobe
// every div+1 cycles for as long as en stays high.
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] cnt_r;

  assign strobe = en & (cnt_r == div_r);

  // Divisor is captured once per frame so software writes cannot stretch a half-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= '0;
      cnt_r <= '0;
    end else if (load) begin
      div_r <= div;
      cnt_r <= '0;
    end else if (strobe) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + DIV_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// APB3 SPI master: register file, transfer FSM and shift registers for one
// full-duplex MSB-first frame per START. Optional IRQ output with SPI_IRQ_EN.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int ADDR_W = 5
) (
  input  logic            PCLK,
  input  logic            PRESET,
  spi_xfer_ctrl_if.slave  apb,
  output logic            SCLK,
  output logic            MOSI,
  input  logic            MISO,
  output logic            CS_N
`ifdef SPI_IRQ_EN
  ,
  output logic            IRQ
`endif
);

  localparam int HP_W = $clog2(2 * DATA_W) + 1;

  spi_state_t        state_r;
  spi_state_t        state_nx_s;

  logic              cpol_r;
  logic              cpol_lat_r;
  logic              irq_en_r;
  logic              done_r;
  logic [DATA_W-1:0] tx_data_r;
  logic [DATA_W-1:0] rx_data_r;
  logic [DIV_W-1:0]  clkdiv_r;
  logic [DATA_W-1:0] tx_sh_r;
  logic [DATA_W-1:0] rx_sh_r;
  logic [HP_W-1:0]   hp_cnt_r;
  logic              sclk_r;
  logic              mosi_r;
  logic              cs_n_r;

  logic              acc_s;
  logic              wr_s;
  logic              sel_ctrl_s;
  logic              sel_status_s;
  logic              sel_tx_s;
  logic              sel_rx_s;
  logic              sel_div_s;
  logic              mapped_s;
  logic              err_s;
  logic              busy_s;
  logic              start_s;
  logic              lead_s;
  logic              trail_s;
  logic              finish_s;
  logic              strobe_s;
  logic              div_en_s;
  logic [DATA_W-1:0] tx_shl_s;
  logic [DATA_W-1:0] rx_nx_s;
  logic [31:0]       rdata_s;
  logic              unused_bits_s;

  assign acc_s        = apb.PSEL & apb.PENABLE;
  assign wr_s         = acc_s & apb.PWRITE;
  assign sel_ctrl_s   = addr_is(8'(apb.PADDR), OFF_CTRL);
  assign sel_status_s = addr_is(8'(apb.PADDR), OFF_STATUS);
  assign sel_tx_s     = addr_is(8'(apb.PADDR), OFF_TXDATA);
  assign sel_rx_s     = addr_is(8'(apb.PADDR), OFF_RXDATA);
  assign sel_div_s    = addr_is(8'(apb.PADDR), OFF_CLKDIV);
  assign mapped_s     = sel_ctrl_s | sel_status_s | sel_tx_s | sel_rx_s | sel_div_s;
  assign busy_s       = (state_r != IDLE);

  // Offending writes are reported here and suppressed at each register's write enable.
  assign err_s = acc_s & (~mapped_s
                        | (apb.PWRITE & sel_rx_s)
                        | (apb.PWRITE & sel_tx_s & busy_s));

  assign start_s  = wr_s & sel_ctrl_s & apb.PWDATA[CTRL_START] & ~busy_s;
  assign div_en_s = (state_r == LOAD) | (state_r == SHIFT);
  assign tx_shl_s = tx_sh_r << 1;
  assign rx_nx_s  = (rx_sh_r << 1) | DATA_W'(MISO);

  assign unused_bits_s = ^apb.PWDATA;

  spi_clk_div #(
    .DIV_W (DIV_W)
  ) u_clk_div (
    .clk    (PCLK),
    .rst    (PRESET),
    .load   (start_s),
    .en     (div_en_s),
    .div    (clkdiv_r),
    .strobe (strobe_s)
  );

  // Transfer state register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and SCLK edge classification; LOAD ends on a leading edge, then SHIFT alternates.
  always_comb begin
    state_nx_s = state_r;
    lead_s     = 1'b0;
    trail_s    = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nx_s = LOAD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD: begin
        if (strobe_s) begin
          lead_s     = 1'b1;
          state_nx_s = SHIFT;
        end else begin
          state_nx_s = LOAD;
        end
      end
      SHIFT: begin
        if (!strobe_s) begin
          state_nx_s = SHIFT;
        end else if (hp_cnt_r == HP_W'(2 * DATA_W - 1)) begin
          state_nx_s = DONE;
        end else if (!hp_cnt_r[0]) begin
          trail_s = 1'b1;
        end else begin
          lead_s = 1'b1;
        end
      end
      DONE: begin
        finish_s   = 1'b1;
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Half-period index within SHIFT.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      hp_cnt_r <= '0;
    end else if (state_r == IDLE) begin
      hp_cnt_r <= '0;
    end else if ((state_r == SHIFT) && strobe_s) begin
      hp_cnt_r <= hp_cnt_r + HP_W'(1);
    end else begin
      hp_cnt_r <= hp_cnt_r;
    end
  end

  // Pad drivers and shift registers; CPOL is captured from the START write itself.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cs_n_r     <= 1'b1;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      cpol_lat_r <= 1'b0;
      tx_sh_r    <= '0;
      rx_sh_r    <= '0;
    end else begin
      cs_n_r <= (state_nx_s == IDLE);
      if (start_s) begin
        cpol_lat_r <= apb.PWDATA[CTRL_CPOL];
        sclk_r     <= apb.PWDATA[CTRL_CPOL];
        tx_sh_r    <= tx_data_r;
        mosi_r     <= tx_data_r[DATA_W-1];
        rx_sh_r    <= '0;
      end else if (lead_s) begin
        sclk_r  <= ~cpol_lat_r;
        rx_sh_r <= rx_nx_s;
      end else if (trail_s) begin
        sclk_r  <= cpol_lat_r;
        tx_sh_r <= tx_shl_s;
        mosi_r  <= tx_shl_s[DATA_W-1];
      end else if (state_r == IDLE) begin
        sclk_r <= cpol_r;
      end else begin
        sclk_r <= sclk_r;
      end
    end
  end

  // Software-visible registers; the DONE set takes priority over a same-cycle w1c.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cpol_r    <= 1'b0;
      irq_en_r  <= 1'b0;
      tx_data_r <= '0;
      clkdiv_r  <= '0;
      done_r    <= 1'b0;
      rx_data_r <= '0;
    end else begin
      if (wr_s && sel_ctrl_s) begin
        cpol_r <= apb.PWDATA[CTRL_CPOL];
`ifdef SPI_IRQ_EN
        irq_en_r <= apb.PWDATA[CTRL_IRQ_EN];
`else
        irq_en_r <= 1'b0;
`endif
      end
      if (wr_s && sel_tx_s && !busy_s) begin
        tx_data_r <= apb.PWDATA[DATA_W-1:0];
      end
      if (wr_s && sel_div_s) begin
        clkdiv_r <= apb.PWDATA[DIV_W-1:0];
      end
      if (finish_s) begin
        done_r    <= 1'b1;
        rx_data_r <= rx_sh_r;
      end else if (wr_s && sel_status_s && apb.PWDATA[STATUS_DONE]) begin
        done_r <= 1'b0;
      end
    end
  end

  // Read mux, zero whenever the slave is not selected.
  always_comb begin
    rdata_s = 32'h0;
    if (apb.PSEL) begin
      case (1'b1)
        sel_ctrl_s:   rdata_s = {29'h0, irq_en_r, cpol_r, 1'b0};
        sel_status_s: rdata_s = {30'h0, done_r, busy_s};
        sel_tx_s:     rdata_s = 32'(tx_data_r);
        sel_rx_s:     rdata_s = 32'(rx_data_r);
        sel_div_s:    rdata_s = 32'(clkdiv_r);
        default:      rdata_s = 32'h0;
      endcase
    end else begin
      rdata_s = 32'h0;
    end
  end

  assign apb.PRDATA  = rdata_s;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = err_s;

  assign SCLK = sclk_r;
  assign MOSI = mosi_r;
  assign CS_N = cs_n_r;

`ifdef SPI_IRQ_EN
  assign IRQ = done_r & irq_en_r;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: register table, loopback/CPOL frames,
// randomized frames against an SPI-level model, and timing corner sequences.
module tb_spi_xfer_ctrl;
  import spi_pkg::*;

  localparam int W = 8;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  logic SCLK, MOSI, MISO, CS_N;
`ifdef SPI_IRQ_EN
  logic IRQ;
  localparam logic [31:0] CTRL_RB = 32'h6;
`else
  localparam logic [31:0] CTRL_RB = 32'h2;
`endif

  spi_xfer_ctrl_if #(.ADDR_W(5)) apb_bus ();

  spi_xfer_ctrl #(.DATA_W(W), .DIV_W(8), .ADDR_W(5)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .apb    (apb_bus),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO),
    .CS_N   (CS_N)
`ifdef SPI_IRQ_EN
    ,
    .IRQ    (IRQ)
`endif
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad = 0;

  // MISO source: 0 fixed level, 1 loopback, 2 per-bit pattern indexed by leading edges seen
  logic [1:0]  miso_mode = 2'd0;
  logic        miso_fix = 1'b0;
  logic [31:0] miso_word = 32'h0;
  logic        cpol_exp = 1'b0;
  logic        irq_exp = 1'b0;
  logic        miso_s;

  int          cs_low_cnt = 0;
  int          lead_cnt = 0;
  int          frame_cnt = 0;
  logic [31:0] mosi_seq = 32'h0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;

  always_comb begin
    miso_s = miso_fix;
    if (miso_mode == 2'd1) miso_s = MOSI;
    else if (miso_mode == 2'd2 && lead_cnt < W) miso_s = miso_word[W-1-lead_cnt];
  end
  assign MISO = miso_s;

  // SPI pad observer: frame length, leading-edge count and MOSI bit at each leading edge
  always @(negedge PCLK) begin
    if (!CS_N && prev_cs) begin
      cs_low_cnt <= 1;
      lead_cnt   <= 0;
      mosi_seq   <= 32'h0;
      frame_cnt  <= frame_cnt + 1;
    end else if (!CS_N) begin
      cs_low_cnt <= cs_low_cnt + 1;
      if (SCLK != cpol_exp && prev_sclk == cpol_exp) begin
        lead_cnt <= lead_cnt + 1;
        mosi_seq <= {mosi_seq[30:0], MOSI};
      end
    end
    prev_cs   <= CS_N;
    prev_sclk <= SCLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                     output logic [31:0] rd, output logic err);
    apb_bus.PSEL    = 1'b1;
    apb_bus.PENABLE = 1'b0;
    apb_bus.PWRITE  = wr;
    apb_bus.PADDR   = addr;
    apb_bus.PWDATA  = data;
    @(posedge PCLK); #1;
    apb_bus.PENABLE = 1'b1;
    #2;
    rd  = apb_bus.PRDATA;
    err = apb_bus.PSLVERR;
    @(posedge PCLK); #1;
    apb_bus.PSEL    = 1'b0;
    apb_bus.PENABLE = 1'b0;
    apb_bus.PWRITE  = 1'b0;
  endtask

  task automatic wr_reg(input logic [4:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic err;
    apb(1'b1, addr, data, rd, err);
  endtask

  task automatic wr_chk(input string name, input logic [4:0] addr, input logic [31:0] data,
                        input logic exp_err);
    logic [31:0] rd;
    logic err;
    apb(1'b1, addr, data, rd, err);
    check(name, 32'(err), 32'(exp_err));
  endtask

  task automatic rd_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic err;
    apb(1'b0, addr, 32'h0, rd, err);
    check(name, rd, exp);
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while (CS_N == 1'b0 && n < 5000) begin
      @(negedge PCLK);
      n++;
    end
    total++;
    if (n >= 5000) begin
      bad++;
      $display("FAIL %s_timeout: CS_N still low after %0d cycles, expected high", name, n);
    end
    @(posedge PCLK); #1;
  endtask

  // Configure and issue START; returns #1 after the commit edge with the frame count before it
  task automatic start_frame(input string name, input int d, input logic [7:0] tx,
                             input logic cpol, input logic irq, output int f0);
    wr_reg(5'h10, 32'(d));
    wr_reg(5'h08, 32'(tx));
    wr_reg(5'h00, {29'h0, irq, cpol, 1'b0});
    cpol_exp = cpol;
    irq_exp  = irq;
    repeat (2) @(posedge PCLK);
    #1;
    check({name, "_idle_sclk"}, 32'(SCLK), 32'(cpol));
    f0 = frame_cnt;
    wr_reg(5'h00, {29'h0, irq, cpol, 1'b1});
  endtask

  task automatic finish_frame(input string name, input int d, input logic [7:0] tx,
                              input logic cpol, input logic [7:0] exp_rx, input int f0);
    wait_frame(name);
    check({name, "_cs_low"}, 32'(cs_low_cnt), 32'((2 * W + 1) * (d + 1) + 1));
    check({name, "_pulses"}, 32'(lead_cnt), 32'(W));
    check({name, "_mosi"}, mosi_seq & 32'hFF, 32'(tx));
    check({name, "_frames"}, 32'(frame_cnt - f0), 32'd1);
    check({name, "_sclk_after"}, 32'(SCLK), 32'(cpol));
    rd_chk({name, "_rx"}, 5'h0C, 32'(exp_rx));
    rd_chk({name, "_status"}, 5'h04, 32'h2);
`ifdef SPI_IRQ_EN
    check({name, "_irq_set"}, 32'(IRQ), 32'(irq_exp));
`endif
    wr_reg(5'h04, 32'h2);
`ifdef SPI_IRQ_EN
    check({name, "_irq_clr"}, 32'(IRQ), 32'h0);
`endif
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        chk_rd;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int f0;
    logic [31:0] rd;
    logic err;
    logic [7:0] tx;
    logic [7:0] mw;
    int d;
    logic cp;

    vecs[0]  = '{1'b0, 5'h00, 32'h0,        32'h0,    1'b0, 1'b1};
    vecs[1]  = '{1'b0, 5'h04, 32'h0,        32'h0,    1'b0, 1'b1};
    vecs[2]  = '{1'b0, 5'h08, 32'h0,        32'h0,    1'b0, 1'b1};
    vecs[3]  = '{1'b0, 5'h0C, 32'h0,        32'h0,    1'b0, 1'b1};
    vecs[4]  = '{1'b0, 5'h10, 32'h0,        32'h0,    1'b0, 1'b1};
    vecs[5]  = '{1'b1, 5'h08, 32'h1A5,      32'h0,    1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'h08, 32'h0,        32'hA5,   1'b0, 1'b1};
    vecs[7]  = '{1'b1, 5'h10, 32'hFFFF_FF03, 32'h0,   1'b0, 1'b0};
    vecs[8]  = '{1'b0, 5'h10, 32'h0,        32'h3,    1'b0, 1'b1};
    vecs[9]  = '{1'b1, 5'h00, 32'h6,        32'h0,    1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'h00, 32'h0,        CTRL_RB,  1'b0, 1'b1};
    vecs[11] = '{1'b1, 5'h00, 32'h0,        32'h0,    1'b0, 1'b0};
    vecs[12] = '{1'b1, 5'h0C, 32'h55,       32'h0,    1'b1, 1'b0};
    vecs[13] = '{1'b0, 5'h0C, 32'h0,        32'h0,    1'b0, 1'b1};
    vecs[14] = '{1'b0, 5'h14, 32'h0,        32'h0,    1'b1, 1'b1};
    vecs[15] = '{1'b1, 5'h18, 32'h7,        32'h0,    1'b1, 1'b0};
    vecs[16] = '{1'b1, 5'h04, 32'h3,        32'h0,    1'b0, 1'b0};
    vecs[17] = '{1'b0, 5'h04, 32'h0,        32'h0,    1'b0, 1'b1};

    apb_bus.PSEL = 1'b0;
    apb_bus.PENABLE = 1'b0;
    apb_bus.PWRITE = 1'b0;
    apb_bus.PADDR = 5'h0;
    apb_bus.PWDATA = 32'h0;

    // Reset state
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_cs_n", 32'(CS_N), 32'h1);
    check("rst_sclk", 32'(SCLK), 32'h0);
    check("rst_mosi", 32'(MOSI), 32'h0);
    check("rst_prdata", apb_bus.PRDATA, 32'h0);
    check("rst_pslverr", 32'(apb_bus.PSLVERR), 32'h0);
    check("pready", 32'(apb_bus.PREADY), 32'h1);
`ifdef SPI_IRQ_EN
    check("rst_irq", 32'(IRQ), 32'h0);
`endif
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    for (int i = 0; i < 18; i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, err);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
    end

    // Loopback 0xA5, CLKDIV=1, with mid-frame error and ignored re-START
    miso_mode = 2'd1;
    start_frame("loop", 1, 8'hA5, 1'b0, 1'b0, f0);
    wr_chk("loop_tx_busy_err", 5'h08, 32'h11, 1'b1);
    wr_chk("loop_restart_noerr", 5'h00, 32'h1, 1'b0);
    rd_chk("loop_busy", 5'h04, 32'h1);
    finish_frame("loop", 1, 8'hA5, 1'b0, 8'hA5, f0);
    rd_chk("loop_tx_kept", 5'h08, 32'hA5);
    repeat (40) @(posedge PCLK);
    #1;
    check("loop_one_frame", 32'(frame_cnt - f0), 32'd1);
    check("loop_cs_idle", 32'(CS_N), 32'h1);

    // CPOL=1, MISO tied high
    miso_mode = 2'd0;
    miso_fix = 1'b1;
    start_frame("cpol", 2, 8'h3C, 1'b1, 1'b0, f0);
    finish_frame("cpol", 2, 8'h3C, 1'b1, 8'hFF, f0);

    // Randomized frames against the pad-level model
    miso_mode = 2'd2;
    for (int i = 0; i < 8; i++) begin
      tx = 8'($urandom);
      mw = 8'($urandom);
      d = int'($urandom_range(0, 3));
      cp = 1'($urandom);
      miso_word = 32'(mw);
      start_frame($sformatf("rnd%0d", i), d, tx, cp, 1'($urandom), f0);
      finish_frame($sformatf("rnd%0d", i), d, tx, cp, mw, f0);
    end

    // DONE set and w1c on the same edge: frame of 35 cycles, w1c commits on the last
    miso_mode = 2'd0;
    miso_fix = 1'b0;
    start_frame("coll", 1, 8'h5A, 1'b0, 1'b1, f0);
    repeat ((2 * W + 1) * 2 + 1 - 2) @(posedge PCLK);
    #1;
    wr_reg(5'h04, 32'h2);
    rd_chk("coll_done_wins", 5'h04, 32'h2);
`ifdef SPI_IRQ_EN
    check("coll_irq", 32'(IRQ), 32'h1);
`endif
    wr_reg(5'h04, 32'h2);
    rd_chk("coll_done_cleared", 5'h04, 32'h0);
    check("coll_cs_n", 32'(CS_N), 32'h1);

    // Reset during SHIFT half-period 5
    start_frame("prst", 1, 8'hC3, 1'b0, 1'b1, f0);
    repeat (12) @(posedge PCLK);
    #1;
    check("prst_cs_before", 32'(CS_N), 32'h0);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("prst_cs_n", 32'(CS_N), 32'h1);
    check("prst_sclk", 32'(SCLK), 32'h0);
    check("prst_mosi", 32'(MOSI), 32'h0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    rd_chk("prst_status", 5'h04, 32'h0);
    rd_chk("prst_rx", 5'h0C, 32'h0);
    rd_chk("prst_clkdiv", 5'h10, 32'h0);
`ifdef SPI_IRQ_EN
    check("prst_irq", 32'(IRQ), 32'h0);
`endif
    repeat (20) @(posedge PCLK);
    #1;
    check("prst_no_new_frame", 32'(frame_cnt - f0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
